// File: rtl/vec_operand_exec_if.sv
// Issue / BRAM / writeback bundle for vec_operand_exec.
// master = issue, BRAM and writeback side; slave = the exec block itself.
interface vec_operand_exec_if #(
  parameter int LANES      = 4,
  parameter int ELEM_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int OP_WIDTH   = 3
) ();
  logic                        latch_en;
  logic [OP_WIDTH-1:0]         op_in;
  logic [ADDR_WIDTH-1:0]       rd_in;
  logic [LANES*ELEM_WIDTH-1:0] rd_data;
  logic                        stall;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*ELEM_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0]       out_rd;
  logic [LANES-1:0]            out_sat;
  logic                        ovf_err;

  modport master (
    output latch_en, op_in, rd_in, rd_data, out_ready,
    input  stall, out_valid, out_data, out_rd, out_sat, ovf_err
  );

  modport slave (
    input  latch_en, op_in, rd_in, rd_data, out_ready,
    output stall, out_valid, out_data, out_rd, out_sat, ovf_err
  );
endinterface

// File: rtl/vec_operand_exec.sv
// Collects rs1/rs2 from BRAM, runs a lane-wise vector ALU op, queues results in a 2-deep FIFO.
// Optional macro SAT_ARITH_EN: signed saturating ADD/SUB with per-lane clip flags on out_sat.
module vec_operand_exec #(
  parameter int LANES      = 4,
  parameter int ELEM_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int OP_WIDTH   = 3
) (
  input  logic              clk,
  input  logic              rst,
  vec_operand_exec_if.slave bus
);

  localparam int VW  = LANES * ELEM_WIDTH;
  localparam int MSB = ELEM_WIDTH - 1;

  localparam logic [OP_WIDTH-1:0] OP_ADD   = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_SUB   = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_AND   = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_OR    = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_XOR   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_MIN   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_MAX   = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_PASSA = OP_WIDTH'(7);

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_GET_A = 2'd1,
    PH_GET_B = 2'd2
  } phase_e;

  phase_e                phase_q, phase_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [VW-1:0]         a_q, a_d;
  logic                  ovf_q, ovf_d;
  logic [VW-1:0]         mem_data_q [2];
  logic [VW-1:0]         mem_data_d [2];
  logic [ADDR_WIDTH-1:0] mem_rd_q [2];
  logic [ADDR_WIDTH-1:0] mem_rd_d [2];
  logic                  rptr_q, rptr_d;
  logic                  wptr_q, wptr_d;
  logic [1:0]            cnt_q, cnt_d;

  logic                  stall_s, accept_s, bad_strobe_s, push_s, pop_s;
  logic [VW-1:0]         wrap_s, res_s;

  function automatic logic [ELEM_WIDTH-1:0] lane_alu(input logic [OP_WIDTH-1:0]   op,
                                                     input logic [ELEM_WIDTH-1:0] a,
                                                     input logic [ELEM_WIDTH-1:0] b);
    logic [ELEM_WIDTH-1:0] r;
    case (op)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_MIN:   r = ($signed(a) < $signed(b)) ? a : b;
      OP_MAX:   r = ($signed(a) > $signed(b)) ? a : b;
      OP_PASSA: r = a;
      default:  r = a;
    endcase
    return r;
  endfunction

`ifdef SAT_ARITH_EN
  localparam logic [ELEM_WIDTH-1:0] ELEM_MIN = {1'b1, {(ELEM_WIDTH-1){1'b0}}};
  localparam logic [ELEM_WIDTH-1:0] ELEM_MAX = {1'b0, {(ELEM_WIDTH-1){1'b1}}};

  logic [LANES-1:0] sat_s;
  logic [LANES-1:0] mem_sat_q [2];
  logic [LANES-1:0] mem_sat_d [2];

  // Signed overflow from sign bits of a, b and the wrapped result; clip direction follows a.
  function automatic logic lane_clip(input logic [OP_WIDTH-1:0] op,
                                     input logic sa, input logic sb, input logic sr);
    logic c;
    if (op == OP_ADD) begin
      c = (sa == sb) && (sr != sa);
    end else if (op == OP_SUB) begin
      c = (sa != sb) && (sr != sa);
    end else begin
      c = 1'b0;
    end
    return c;
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_IDLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_IDLE:  phase_d = accept_s ? PH_GET_A : PH_IDLE;
      PH_GET_A: phase_d = PH_GET_B;
      PH_GET_B: phase_d = accept_s ? PH_GET_A : PH_IDLE;
      default:  phase_d = PH_IDLE;
    endcase
  end

  // A strobe in GET_A would collide with the A read, so it is dropped like a stalled one.
  always_comb begin
    stall_s      = (3'(cnt_q) + 3'(phase_q != PH_IDLE)) >= 3'd2;
    accept_s     = 1'b0;
    bad_strobe_s = 1'b0;
    if (bus.latch_en) begin
      if (stall_s || (phase_q == PH_GET_A)) begin
        bad_strobe_s = 1'b1;
      end else begin
        accept_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
    end
    push_s = (phase_q == PH_GET_B);
    pop_s  = (cnt_q != 2'd0) && bus.out_ready;
  end

  always_comb begin
    op_d  = accept_s ? bus.op_in : op_q;
    rd_d  = accept_s ? bus.rd_in : rd_q;
    a_d   = (phase_q == PH_GET_A) ? bus.rd_data : a_q;
    ovf_d = ovf_q | bad_strobe_s;
  end

  always_comb begin
    wrap_s = '0;
    res_s  = '0;
`ifdef SAT_ARITH_EN
    sat_s  = '0;
`endif
    for (int i = 0; i < LANES; i++) begin
      wrap_s[i*ELEM_WIDTH +: ELEM_WIDTH] = lane_alu(op_q, a_q[i*ELEM_WIDTH +: ELEM_WIDTH],
                                                    bus.rd_data[i*ELEM_WIDTH +: ELEM_WIDTH]);
`ifdef SAT_ARITH_EN
      sat_s[i] = lane_clip(op_q, a_q[i*ELEM_WIDTH + MSB], bus.rd_data[i*ELEM_WIDTH + MSB],
                           wrap_s[i*ELEM_WIDTH + MSB]);
      res_s[i*ELEM_WIDTH +: ELEM_WIDTH] = !sat_s[i] ? wrap_s[i*ELEM_WIDTH +: ELEM_WIDTH]
                                          : (a_q[i*ELEM_WIDTH + MSB] ? ELEM_MIN : ELEM_MAX);
`else
      res_s[i*ELEM_WIDTH +: ELEM_WIDTH] = wrap_s[i*ELEM_WIDTH +: ELEM_WIDTH];
`endif
    end
  end

  // Push always targets the non-head slot, so the head stays stable under back-pressure.
  always_comb begin
    mem_data_d = mem_data_q;
    mem_rd_d   = mem_rd_q;
`ifdef SAT_ARITH_EN
    mem_sat_d  = mem_sat_q;
`endif
    if (push_s) begin
      mem_data_d[wptr_q] = res_s;
      mem_rd_d[wptr_q]   = rd_q;
`ifdef SAT_ARITH_EN
      mem_sat_d[wptr_q]  = sat_s;
`endif
    end else begin
      mem_rd_d = mem_rd_q;
    end
    wptr_d = wptr_q ^ push_s;
    rptr_d = rptr_q ^ pop_s;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      rd_q   <= '0;
      a_q    <= '0;
      ovf_q  <= 1'b0;
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
      cnt_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_data_q[i] <= '0;
        mem_rd_q[i]   <= '0;
`ifdef SAT_ARITH_EN
        mem_sat_q[i]  <= '0;
`endif
      end
    end else begin
      op_q       <= op_d;
      rd_q       <= rd_d;
      a_q        <= a_d;
      ovf_q      <= ovf_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      cnt_q      <= cnt_d;
      mem_data_q <= mem_data_d;
      mem_rd_q   <= mem_rd_d;
`ifdef SAT_ARITH_EN
      mem_sat_q  <= mem_sat_d;
`endif
    end
  end

  assign bus.stall     = stall_s;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = mem_data_q[rptr_q];
  assign bus.out_rd    = mem_rd_q[rptr_q];
  assign bus.ovf_err   = ovf_q;
`ifdef SAT_ARITH_EN
  assign bus.out_sat   = mem_sat_q[rptr_q];
`else
  assign bus.out_sat   = '0;
`endif

endmodule

// File: tb/tb_vec_operand_exec.sv
// Self-checking bench for vec_operand_exec: directed scenarios plus randomized traffic
// compared against an integer-arithmetic reference model and an expected-result queue.
module tb_vec_operand_exec;
  localparam int LANES = 4;
  localparam int EW    = 8;
  localparam int AW    = 5;
  localparam int OW    = 3;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_MIN = 3'd5, OP_MAX = 3'd6, OP_PASSA = 3'd7;

  typedef struct { logic [31:0] data; logic [4:0] rd; logic [3:0] sat; } res_t;
  typedef struct { logic [2:0] op; logic [4:0] rd; logic [31:0] a; logic [31:0] b; } op_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  vec_operand_exec_if #(.LANES(LANES), .ELEM_WIDTH(EW), .ADDR_WIDTH(AW), .OP_WIDTH(OW)) bus ();

  vec_operand_exec #(.LANES(LANES), .ELEM_WIDTH(EW), .ADDR_WIDTH(AW), .OP_WIDTH(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  op_t  cur;
  int   cur_stage = 0;
  logic m_ovf = 1'b0;

  // Lane results from plain signed integer arithmetic, then clamped or wrapped to a byte.
  function automatic res_t ref_vec(input op_t o);
    res_t r;
    int   sa, sb, v;
    r.rd   = o.rd;
    r.data = '0;
    r.sat  = '0;
    for (int i = 0; i < LANES; i++) begin
      sa = byte'(o.a[8*i +: 8]);
      sb = byte'(o.b[8*i +: 8]);
      case (o.op)
        OP_ADD:  v = sa + sb;
        OP_SUB:  v = sa - sb;
        OP_AND:  v = int'(o.a[8*i +: 8] & o.b[8*i +: 8]);
        OP_OR:   v = int'(o.a[8*i +: 8] | o.b[8*i +: 8]);
        OP_XOR:  v = int'(o.a[8*i +: 8] ^ o.b[8*i +: 8]);
        OP_MIN:  v = (sa < sb) ? sa : sb;
        OP_MAX:  v = (sa > sb) ? sa : sb;
        default: v = sa;
      endcase
`ifdef SAT_ARITH_EN
      if (o.op == OP_ADD || o.op == OP_SUB) begin
        if (v > 127) begin
          v = 127;
          r.sat[i] = 1'b1;
        end else if (v < -128) begin
          v = -128;
          r.sat[i] = 1'b1;
        end
      end
`endif
      r.data[8*i +: 8] = v[7:0];
    end
    return r;
  endfunction

  function automatic logic m_stall();
    return (exp_q.size() + ((cur_stage != 0) ? 1 : 0)) >= 2;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    cur_stage = 0;
    m_ovf     = 1'b0;
  endtask

  // One clock: drive strobe/ready, feed BRAM data for the op in flight, advance the model.
  task automatic step(input logic strobe, input logic [2:0] op, input logic [4:0] rd,
                      input logic [31:0] a, input logic [31:0] b, input logic rdy);
    logic legal;
    legal         = strobe && !m_stall() && (cur_stage != 1);
    bus.latch_en  = strobe;
    bus.op_in     = op;
    bus.rd_in     = rd;
    bus.out_ready = rdy;
    bus.rd_data   = (cur_stage == 1) ? cur.a : (cur_stage == 2) ? cur.b : $urandom();
    @(posedge clk);
    #1;
    if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
    if (cur_stage == 2) exp_q.push_back(ref_vec(cur));
    if (strobe && !legal) m_ovf = 1'b1;
    if (legal) begin
      cur.op = op; cur.rd = rd; cur.a = a; cur.b = b;
      cur_stage = 1;
    end else if (cur_stage == 1) begin
      cur_stage = 2;
    end else begin
      cur_stage = 0;
    end
    bus.latch_en = 1'b0;
  endtask

  task automatic do_reset();
    bus.latch_en  = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    bus.latch_en = 1'b0; bus.op_in = '0; bus.rd_in = '0; bus.rd_data = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.stall, bus.ovf_err, bus.out_sat, bus.out_rd, bus.out_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b st=%b ovf=%b sat=%h rd=%h data=%h want all 0",
               bus.out_valid, bus.stall, bus.ovf_err, bus.out_sat, bus.out_rd, bus.out_data);
    end
    rst = 1'b0;
    model_clear();
    step(1'b1, OP_ADD, 5'd5, $urandom(), $urandom(), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    for (int k = 0; k < 6; k++) begin
      step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_midop_valid: cycle %0d got %b want 0", k, bus.out_valid);
      end
    end
    checks++;
    if ({bus.stall, bus.ovf_err} !== 2'b00) begin
      errors++;
      $display("FAIL reset_midop_flags: got stall=%b ovf=%b want 0 0", bus.stall, bus.ovf_err);
    end
  endtask

  task automatic test_add();
    logic [31:0] exp_data;
    logic [3:0]  exp_sat;
`ifdef SAT_ARITH_EN
    exp_data = 32'h00007F02; exp_sat = 4'b0010;
`else
    exp_data = 32'h00008002; exp_sat = 4'b0000;
`endif
    do_reset();
    step(1'b1, OP_ADD, 5'd3, 32'h10FF7F01, 32'hF0010101, 1'b0);
    step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_early_valid: got %b want 0 at t+2", bus.out_valid);
    end
    step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if ({bus.out_valid, bus.out_rd, bus.out_data, bus.out_sat} !== {1'b1, 5'd3, exp_data, exp_sat}) begin
      errors++;
      $display("FAIL add_result: got v=%b rd=%0d data=%h sat=%b want v=1 rd=3 data=%h sat=%b",
               bus.out_valid, bus.out_rd, bus.out_data, bus.out_sat, exp_data, exp_sat);
    end
    step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_pop: got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(1'b1, OP_ADD, 5'd7, $urandom(), $urandom(), 1'b0);
    step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, OP_XOR, 5'd9, $urandom(), $urandom(), 1'b0);
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall_t3: got %b want 1", bus.stall);
    end
    step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if (bus.ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ovf_early: got %b want 0", bus.ovf_err);
    end
    step(1'b1, OP_OR, 5'd11, $urandom(), $urandom(), 1'b0);
    checks++;
    if ({bus.ovf_err, bus.stall, bus.out_valid} !== 3'b111) begin
      errors++;
      $display("FAIL b2b_third_strobe: got ovf=%b stall=%b valid=%b want 1 1 1",
               bus.ovf_err, bus.stall, bus.out_valid);
    end
    step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_rd !== ((k == 0) ? 5'd7 : 5'd9) ||
          exp_q.size() == 0 || bus.out_data !== exp_q[0].data) begin
        errors++;
        $display("FAIL b2b_pop%0d: got v=%b rd=%0d data=%h want v=1 rd=%0d data=%h", k,
                 bus.out_valid, bus.out_rd, bus.out_data, (k == 0) ? 7 : 9,
                 (exp_q.size() > 0) ? exp_q[0].data : 32'hx);
      end
      step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b1);
    end
    checks++;
    if ({bus.out_valid, bus.ovf_err} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_drained: got valid=%b ovf=%b want 0 1", bus.out_valid, bus.ovf_err);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    step(1'b1, OP_SUB, 5'd4, $urandom(), $urandom(), 1'b0);
    step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b0);
    step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, OP_AND, 5'd6, $urandom(), $urandom(), 1'b0);
    step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b0);
    checks++;
    if ({bus.stall, bus.out_valid, bus.out_rd} !== {1'b1, 1'b1, 5'd4}) begin
      errors++;
      $display("FAIL pp_before: got stall=%b v=%b rd=%0d want 1 1 4", bus.stall, bus.out_valid, bus.out_rd);
    end
    step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b1);
    checks++;
    if ({bus.stall, bus.out_valid, bus.out_rd} !== {1'b0, 1'b1, 5'd6} ||
        exp_q.size() != 1 || bus.out_data !== exp_q[0].data) begin
      errors++;
      $display("FAIL pp_after: got stall=%b v=%b rd=%0d data=%h want 0 1 6 data=%h",
               bus.stall, bus.out_valid, bus.out_rd, bus.out_data,
               (exp_q.size() > 0) ? exp_q[0].data : 32'hx);
    end
    step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic test_minmax();
    logic [31:0] a, b;
    do_reset();
    a = {16'($urandom()), 16'h0580};
    b = {16'($urandom()), 16'hFB7F};
    for (int k = 0; k < 2; k++) begin
      step(1'b1, (k == 0) ? OP_MIN : OP_MAX, 5'd12, a, b, 1'b0);
      step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b0);
      step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data[15:0] !== ((k == 0) ? 16'hFB80 : 16'h057F) ||
          exp_q.size() == 0 || bus.out_data !== exp_q[0].data) begin
        errors++;
        $display("FAIL %s: got v=%b data=%h want low16=%h data=%h", (k == 0) ? "min" : "max",
                 bus.out_valid, bus.out_data, (k == 0) ? 16'hFB80 : 16'h057F,
                 (exp_q.size() > 0) ? exp_q[0].data : 32'hx);
      end
      step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b1);
    end
  endtask

  task automatic test_hold();
    logic [31:0] a;
    do_reset();
    a = $urandom();
    step(1'b1, OP_PASSA, 5'd21, a, $urandom(), 1'b0);
    step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b0);
    step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b0);
      checks++;
      if ({bus.out_valid, bus.out_rd, bus.out_data} !== {1'b1, 5'd21, a}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got v=%b rd=%0d data=%h want 1 21 %h", k,
                 bus.out_valid, bus.out_rd, bus.out_data, a);
      end
    end
    step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic test_random();
    logic strobe;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (bus.stall !== m_stall() || bus.out_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL rand_ctrl: cycle %0d got stall=%b v=%b want %b %b", c, bus.stall,
                 bus.out_valid, m_stall(), exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        checks++;
        if ({bus.out_data, bus.out_rd, bus.out_sat} !== {exp_q[0].data, exp_q[0].rd, exp_q[0].sat}) begin
          errors++;
          $display("FAIL rand_head: cycle %0d got data=%h rd=%0d sat=%b want %h %0d %b", c,
                   bus.out_data, bus.out_rd, bus.out_sat, exp_q[0].data, exp_q[0].rd, exp_q[0].sat);
        end
      end
      strobe = ($urandom_range(0, 2) != 0) && !m_stall() && (cur_stage != 1);
      step(strobe, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom(), $urandom(),
           1'($urandom_range(0, 1)));
    end
    repeat (6) step(1'b0, OP_ADD, 5'd0, 32'd0, 32'd0, 1'b1);
    checks++;
    if ({bus.out_valid, bus.stall, bus.ovf_err} !== {1'b0, 1'b0, m_ovf}) begin
      errors++;
      $display("FAIL rand_end: got v=%b stall=%b ovf=%b want 0 0 %b", bus.out_valid, bus.stall,
               bus.ovf_err, m_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_push_pop();
    test_minmax();
    test_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
